chirp_sequencer: RTL and testbench

- Controller that sequences the radar NCO through a frame of linear FM chirps.
- Per sample, generates the frequency word (phase increment), ramps it by a programmable slope, and produces the accumulated phase that drives the sine/cosine LUT indexing stage.
- Counts samples per chirp, inter-chirp idle gaps and chirps per frame, with a start/busy/done handshake toward the radar frame controller.

---
 rtl/chirp_pkg.sv | 16 +
 rtl/chirp_phase_acc.sv | 35 +++
 rtl/chirp_sequencer.sv | 175 +++++++++++++++++
 tb/tb_chirp_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chirp_pkg.sv
// Shared types and default widths for the chirp sequencer and its phase accumulator.
package chirp_pkg;

  localparam int unsigned PW = 22;
  localparam int unsigned SW = 12;
  localparam int unsigned CW = 8;
  localparam int unsigned GW = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/chirp_phase_acc.sv
// Two-stage quadratic accumulator: freq ramps by slope, phase integrates freq (both mod 2^W).
module chirp_phase_acc
  import chirp_pkg::*;
#(
  parameter int unsigned W = PW
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         load_inc_i,
  input  logic         step_i,
  input  logic [W-1:0] start_inc_i,
  input  logic [W-1:0] slope_i,
  output logic [W-1:0] phase_o
);

  logic [W-1:0] freq_q;
  logic [W-1:0] phase_q;

  // Sample 0 restarts at phase 0; later samples add the pre-step freq before it ramps.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      freq_q  <= '0;
      phase_q <= '0;
    end else if (load_inc_i) begin
      freq_q  <= start_inc_i;
      phase_q <= '0;
    end else if (step_i) begin
      phase_q <= phase_q + freq_q;
      freq_q  <= freq_q + slope_i;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/chirp_sequencer.sv
// Frame sequencer for linear FM chirps driving the NCO phase path.
// Optional CHIRP_SEQ_ABORT_EN adds an abort input that returns a running frame to IDLE.
module chirp_sequencer
  import chirp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] cfg_start_inc,
  input  logic [PW-1:0] cfg_slope,
  input  logic [SW-1:0] cfg_num_samples,
  input  logic [CW-1:0] cfg_num_chirps,
  input  logic [GW-1:0] cfg_idle_cycles,
`ifdef CHIRP_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic [PW-1:0] phase,
  output logic          phase_valid,
  output logic          chirp_start,
  output logic [CW-1:0] chirp_idx,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic [PW-1:0] inc_q;
  logic [PW-1:0] slope_q;
  logic [SW-1:0] nsamp_q;
  logic [CW-1:0] nchirp_q;
  logic [GW-1:0] idle_q;
  logic [SW-1:0] samp_q;
  logic [CW-1:0] chirp_q;
  logic [GW-1:0] gap_q;
  logic          valid_q;
  logic          cstart_q;
  logic          busy_q;
  logic          done_q;

  logic          abort_c;
  logic          kill_c;
  logic          start_ok_c;
  logic          last_samp_c;
  logic          last_chirp_c;
  logic          gap_last_c;
  logic          acc_clear_c;
  logic          acc_load_c;
  logic          acc_step_c;
  logic [PW-1:0] acc_inc_c;

  // Decode of the current position in the frame and the accumulator command for this edge.
  always_comb begin
    abort_c      = 1'b0;
`ifdef CHIRP_SEQ_ABORT_EN
    abort_c      = abort && (state_q != IDLE);
`endif
    kill_c       = reset || abort_c;
    start_ok_c   = start && (cfg_num_samples != '0) && (cfg_num_chirps != '0);
    last_samp_c  = (samp_q == (nsamp_q - SW'(1)));
    last_chirp_c = (chirp_q == (nchirp_q - CW'(1)));
    gap_last_c   = (gap_q == idle_q);
    acc_clear_c  = kill_c;
    acc_load_c   = 1'b0;
    acc_step_c   = 1'b0;
    if (!kill_c) begin
      case (state_q)
        IDLE: acc_load_c = start_ok_c;
        RAMP: begin
          if (!last_samp_c) begin
            acc_step_c = 1'b1;
          end else if (!last_chirp_c && (idle_q == '0)) begin
            acc_load_c = 1'b1;
          end
        end
        GAP:     acc_load_c = gap_last_c;
        default: ;
      endcase
    end
    // The shadow is not yet loaded on the starting edge, so take the increment straight from cfg.
    acc_inc_c = (state_q == IDLE) ? cfg_start_inc : inc_q;
  end

  // Frame FSM with counters and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (kill_c) begin
      state_q  <= IDLE;
      inc_q    <= '0;
      slope_q  <= '0;
      nsamp_q  <= '0;
      nchirp_q <= '0;
      idle_q   <= '0;
      samp_q   <= '0;
      chirp_q  <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      cstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cstart_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          chirp_q <= '0;
          if (start_ok_c) begin
            inc_q    <= cfg_start_inc;
            slope_q  <= cfg_slope;
            nsamp_q  <= cfg_num_samples;
            nchirp_q <= cfg_num_chirps;
            idle_q   <= cfg_idle_cycles;
            samp_q   <= '0;
            valid_q  <= 1'b1;
            cstart_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= RAMP;
          end
        end
        RAMP: begin
          if (!last_samp_c) begin
            samp_q <= samp_q + SW'(1);
          end else if (last_chirp_c) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idle_q != '0) begin
            valid_q <= 1'b0;
            gap_q   <= GW'(1);
            state_q <= GAP;
          end else begin
            samp_q   <= '0;
            chirp_q  <= chirp_q + CW'(1);
            cstart_q <= 1'b1;
          end
        end
        GAP: begin
          if (gap_last_c) begin
            samp_q   <= '0;
            chirp_q  <= chirp_q + CW'(1);
            valid_q  <= 1'b1;
            cstart_q <= 1'b1;
            state_q  <= RAMP;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          chirp_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  chirp_phase_acc #(
    .W(PW)
  ) u_acc (
    .clk        (clk),
    .clear_i    (acc_clear_c),
    .load_inc_i (acc_load_c),
    .step_i     (acc_step_c),
    .start_inc_i(acc_inc_c),
    .slope_i    (slope_q),
    .phase_o    (phase)
  );

  assign phase_valid = valid_q;
  assign chirp_start = cstart_q;
  assign chirp_idx   = chirp_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Scoreboard bench for chirp_sequencer: closed-form phase model, timing-tagged expectations.
module tb_chirp_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [21:0] cfg_start_inc;
  logic [21:0] cfg_slope;
  logic [11:0] cfg_num_samples;
  logic [7:0]  cfg_num_chirps;
  logic [9:0]  cfg_idle_cycles;
  logic        abort;
  logic [21:0] phase;
  logic        phase_valid;
  logic        chirp_start;
  logic [7:0]  chirp_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  chirp_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_start_inc  (cfg_start_inc),
    .cfg_slope      (cfg_slope),
    .cfg_num_samples(cfg_num_samples),
    .cfg_num_chirps (cfg_num_chirps),
    .cfg_idle_cycles(cfg_idle_cycles),
`ifdef CHIRP_SEQ_ABORT_EN
    .abort          (abort),
`endif
    .phase          (phase),
    .phase_valid    (phase_valid),
    .chirp_start    (chirp_start),
    .chirp_idx      (chirp_idx),
    .busy           (busy),
    .done           (done)
  );

  typedef struct {
    int          cyc;
    logic [21:0] ph;
    logic        cs;
    logic [7:0]  idx;
  } exp_t;

  exp_t sb_q[$];
  int   done_q[$];
  int   edge_n   = 0;
  int   done_cnt = 0;
  int   n_err    = 0;
  int   n_chk    = 0;
  bit   mon_en   = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, edge_n, act, expv);
    end
  endtask

  // Closed form: phase_k = k*inc + slope*k(k-1)/2 mod 2^22
  function automatic logic [21:0] model_phase(input logic [21:0] inc, input logic [21:0] slope,
                                              input int k);
    longint unsigned kk;
    longint unsigned v;
    kk = longint'(k);
    v  = kk * longint'(inc) + longint'(slope) * ((kk * (kk - 1)) / 2);
    return v[21:0];
  endfunction

  // Expected visible cycle of sample (c,k) = t + c*(S+G) + k; done one cycle after the last sample.
  task automatic push_frame(input int t, input logic [21:0] inc, input logic [21:0] slope,
                            input int s, input int c, input int g);
    exp_t e;
    for (int ci = 0; ci < c; ci++) begin
      for (int k = 0; k < s; k++) begin
        e.cyc = t + ci * (s + g) + k;
        e.ph  = model_phase(inc, slope, k);
        e.cs  = (k == 0);
        e.idx = 8'(ci);
        sb_q.push_back(e);
      end
    end
    done_q.push_back(t + c * s + (c - 1) * g);
  endtask

  // Monitor: pops expectations whenever the DUT presents a sample or a done pulse.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (phase_valid === 1'b1) begin
          chk("valid_expected", longint'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("valid_cycle", edge_n, e.cyc);
            chk("phase", phase, e.ph);
            chk("chirp_start", chirp_start, e.cs);
            chk("chirp_idx", chirp_idx, e.idx);
            chk("busy_in_ramp", busy, 1);
          end
        end else begin
          chk("chirp_start_without_valid", chirp_start, 0);
        end
        if (done === 1'b1) begin
          chk("done_expected", longint'(done_q.size() > 0), 1);
          if (done_q.size() > 0) begin
            d = done_q.pop_front();
            chk("done_cycle", edge_n, d);
          end
          chk("busy_at_done", busy, 1);
          done_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic perturb_cfg();
    start           = ($urandom_range(0, 2) == 0);
    cfg_start_inc   = 22'($urandom);
    cfg_slope       = 22'($urandom);
    cfg_num_samples = 12'($urandom_range(0, 15));
    cfg_num_chirps  = 8'($urandom_range(0, 5));
    cfg_idle_cycles = 10'($urandom_range(0, 5));
  endtask

  task automatic run_frame(input logic [21:0] inc, input logic [21:0] slope, input int s,
                           input int c, input int g, input bit perturb, input bit ab);
    int t;
    int d0;
    int n;
    cfg_start_inc   = inc;
    cfg_slope       = slope;
    cfg_num_samples = 12'(s);
    cfg_num_chirps  = 8'(c);
    cfg_idle_cycles = 10'(g);
    start           = 1'b1;
    abort           = ab;
    t               = edge_n + 1;
    d0              = done_cnt;
    push_frame(t, inc, slope, s, c, g);
    tick();
    start = 1'b0;
    abort = 1'b0;
    n     = 0;
    while (done_cnt == d0 && n < 5000) begin
      if (perturb) perturb_cfg();
      tick();
      n++;
    end
    start = 1'b0;
    chk("frame_done_in_time", longint'(done_cnt != d0), 1);
    tick();
    chk("busy_after_done", busy, 0);
    chk("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic zero_count_start(input int s, input int c);
    cfg_start_inc   = 22'd1234;
    cfg_slope       = 22'd5;
    cfg_num_samples = 12'(s);
    cfg_num_chirps  = 8'(c);
    cfg_idle_cycles = 10'd2;
    start           = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("zero_count_busy", busy, 0);
      chk("zero_count_valid", phase_valid, 0);
      tick();
    end
  endtask

  // Kill a frame mid-ramp by reset or abort; outputs clear next cycle and no done follows.
  task automatic kill_test(input bit use_abort);
    logic [21:0] inc;
    logic [21:0] slope;
    int          t;
    inc             = 22'($urandom);
    slope           = 22'($urandom_range(0, 4000));
    cfg_start_inc   = inc;
    cfg_slope       = slope;
    cfg_num_samples = 12'd8;
    cfg_num_chirps  = 8'd2;
    cfg_idle_cycles = 10'd2;
    start           = 1'b1;
    t               = edge_n + 1;
    push_frame(t, inc, slope, 8, 2, 2);
    tick();
    start = 1'b0;
    repeat (3) tick();
    if (use_abort) abort = 1'b1;
    else reset = 1'b1;
    tick();
    abort = 1'b0;
    reset = 1'b0;
    chk("kill_phase", phase, 0);
    chk("kill_valid", phase_valid, 0);
    chk("kill_chirp_start", chirp_start, 0);
    chk("kill_chirp_idx", chirp_idx, 0);
    chk("kill_busy", busy, 0);
    chk("kill_done", done, 0);
    sb_q.delete();
    done_q.delete();
    repeat (6) tick();
    chk("kill_still_idle", busy, 0);
    run_frame(inc, slope, 8, 2, 2, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    cfg_start_inc   = '0;
    cfg_slope       = '0;
    cfg_num_samples = '0;
    cfg_num_chirps  = '0;
    cfg_idle_cycles = '0;
    repeat (3) tick();
    chk("reset_phase", phase, 0);
    chk("reset_valid", phase_valid, 0);
    chk("reset_chirp_start", chirp_start, 0);
    chk("reset_chirp_idx", chirp_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    run_frame(22'd10000, 22'd0, 4, 2, 3, 1'b0, 1'b0);
    run_frame(22'd10000, 22'd100, 4, 1, 0, 1'b0, 1'b0);
    run_frame(22'd4194303, 22'd0, 3, 1, 0, 1'b0, 1'b0);
    run_frame(22'd1000, 22'd4194104, 3, 1, 0, 1'b0, 1'b0);
    run_frame(22'd777, 22'd3, 2, 3, 0, 1'b0, 1'b0);
    zero_count_start(0, 2);
    zero_count_start(3, 0);
    run_frame(22'd10000, 22'd100, 5, 3, 2, 1'b1, 1'b0);
    kill_test(1'b0);
`ifdef CHIRP_SEQ_ABORT_EN
    kill_test(1'b1);
    run_frame(22'd2500, 22'd7, 3, 2, 1, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 25; i++) begin
      run_frame(22'($urandom),
                ($urandom_range(0, 1) == 1) ? 22'($urandom) : 22'($urandom_range(0, 300)),
                int'($urandom_range(1, 10)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
